// File: rtl/reg_file_sb_if.sv
// reg_file_sb bus: read ports, write port, issue port and scoreboard flags.
// Master drives addresses/commands; slave (the register file) returns data and busy.
interface reg_file_sb_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [WIDTH-1:0]  rs_data;
    logic [WIDTH-1:0]  rt_data;
    logic              rs_busy;
    logic              rt_busy;
    logic              we;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic              issue_en;
    logic [ADDR_W-1:0] issue_addr;
    logic              busy_any;

    modport master (
        output rs_addr, rt_addr,
        output we, wr_addr, wr_data,
        output issue_en, issue_addr,
        input  rs_data, rt_data,
        input  rs_busy, rt_busy,
        input  busy_any
    );

    modport slave (
        input  rs_addr, rt_addr,
        input  we, wr_addr, wr_data,
        input  issue_en, issue_addr,
        output rs_data, rt_data,
        output rs_busy, rt_busy,
        output busy_any
    );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with per-register pending-write scoreboard (2R/1W).
// Optional same-cycle write-to-read bypass: define REGFILE_WRITE_BYPASS_EN.
module reg_file_sb #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    reg_file_sb_if.slave bus
);
    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } sb_state_t;

    logic [WIDTH-1:0] rd_arr [DEPTH];
    logic [DEPTH-1:0] busy;

    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        if (ZERO_REG && (i == 0)) begin : g_zero
            assign rd_arr[i] = '0;
            assign busy[i]   = 1'b0;
        end else begin : g_live
            logic [WIDTH-1:0] data_q;
            sb_state_t        state_q;
            sb_state_t        state_d;
            logic             wr_hit;
            logic             iss_hit;

            assign wr_hit  = bus.we
                && (bus.wr_addr == ADDR_W'(i));
            assign iss_hit = bus.issue_en
                && (bus.issue_addr == ADDR_W'(i));

            // Data bits: load on a write hit, otherwise hold.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    data_q <= '0;
                end else if (wr_hit) begin
                    data_q <= bus.wr_data;
                end
            end

            // Scoreboard state register for this destination.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state_q <= IDLE;
                end else begin
                    state_q <= state_d;
                end
            end

            // Issue marks pending; a writeback clears it unless re-issued.
            always_comb begin
                state_d = state_q;
                unique case (state_q)
                    IDLE: begin
                        if (iss_hit) begin
                            state_d = PENDING;
                        end
                    end
                    PENDING: begin
                        if (wr_hit && !iss_hit) begin
                            state_d = IDLE;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end

            assign rd_arr[i] = data_q;
            assign busy[i]   = (state_q == PENDING);
        end
    end

    assign bus.busy_any = |busy;

`ifdef REGFILE_WRITE_BYPASS_EN
    logic rs_zero;
    logic rt_zero;
    logic rs_byp;
    logic rt_byp;

    assign rs_zero = ZERO_REG && (bus.rs_addr == '0);
    assign rt_zero = ZERO_REG && (bus.rt_addr == '0);

    // Reset wins over the bypass so outputs read zero while it is held.
    assign rs_byp = !reset && bus.we && !rs_zero
        && (bus.wr_addr == bus.rs_addr);
    assign rt_byp = !reset && bus.we && !rt_zero
        && (bus.wr_addr == bus.rt_addr);

    // Port A: in-flight write data wins over stored data.
    always_comb begin
        bus.rs_data = rd_arr[bus.rs_addr];
        bus.rs_busy = busy[bus.rs_addr];
        if (rs_byp) begin
            bus.rs_data = bus.wr_data;
            bus.rs_busy = bus.issue_en
                && (bus.issue_addr == bus.rs_addr);
        end
    end

    // Port B: in-flight write data wins over stored data.
    always_comb begin
        bus.rt_data = rd_arr[bus.rt_addr];
        bus.rt_busy = busy[bus.rt_addr];
        if (rt_byp) begin
            bus.rt_data = bus.wr_data;
            bus.rt_busy = bus.issue_en
                && (bus.issue_addr == bus.rt_addr);
        end
    end
`else
    // Port A: stored data and flag only.
    always_comb begin
        bus.rs_data = rd_arr[bus.rs_addr];
        bus.rs_busy = busy[bus.rs_addr];
    end

    // Port B: stored data and flag only.
    always_comb begin
        bus.rt_data = rd_arr[bus.rt_addr];
        bus.rt_busy = busy[bus.rt_addr];
    end
`endif
endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: stimulus pushes expectations,
// a negedge monitor pops and compares the combinational outputs.
module tb_reg_file_sb;
    logic clk;
    logic reset;

    reg_file_sb_if #(.WIDTH(32), .ADDR_W(5)) bus ();

    reg_file_sb #(
        .WIDTH(32),
        .DEPTH(32),
        .ADDR_W(5),
        .ZERO_REG(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

`ifdef REGFILE_WRITE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [66:0] v;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] rs,
                       input logic [31:0] rt, input logic rsb,
                       input logic rtb, input logic any);
        exp_t e;
        e.name = nm;
        e.v    = {rs, rt, rsb, rtb, any};
        q.push_back(e);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.we      = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
    endtask

    task automatic iss(input logic [4:0] a);
        bus.issue_en   = 1'b1;
        bus.issue_addr = a;
    endtask

    task automatic idle();
        bus.we       = 1'b0;
        bus.issue_en = 1'b0;
    endtask

    // Monitor: compare outputs against the oldest pending expectation.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t        e;
            logic [66:0] got;
            e   = q.pop_front();
            got = {bus.rs_data, bus.rt_data,
                   bus.rs_busy, bus.rt_busy, bus.busy_any};
            total++;
            if (got !== e.v) begin
                bad++;
                $display("FAIL %s got=%h exp=%h", e.name, got, e.v);
            end
        end
    end

    initial begin
        reset          = 1'b1;
        bus.rs_addr    = '0;
        bus.rt_addr    = '0;
        bus.we         = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.issue_en   = 1'b0;
        bus.issue_addr = '0;
        step();

        chk("reset_state", 0, 0, 0, 0, 0);
        step();
        reset = 1'b0;

        wr(5, 32'hDEADBEEF);
        step();
        idle();
        bus.rs_addr = 5;
        chk("r5_written", 32'hDEADBEEF, 0, 0, 0, 0);
        step();

        reset = 1'b1;
        wr(6, 32'h1);
        iss(6);
        bus.rt_addr = 6;
        chk("reset_async", 0, 0, 0, 0, 0);
        step();
        reset = 1'b0;
        idle();
        chk("reset_discard", 0, 0, 0, 0, 0);
        step();

        wr(3, 32'h12345678);
        step();
        wr(31, 32'hA5A5A5A5);
        step();
        idle();
        bus.rs_addr = 3;
        bus.rt_addr = 31;
        chk("rd_3_31", 32'h12345678, 32'hA5A5A5A5, 0, 0, 0);
        step();

        for (int k = 0; k < 10; k++) begin
            bus.wr_addr    = 5'($urandom);
            bus.wr_data    = $urandom;
            bus.issue_addr = 5'($urandom);
            step();
        end
        chk("hold_10", 32'h12345678, 32'hA5A5A5A5, 0, 0, 0);
        step();

        wr(0, 32'hFFFFFFFF);
        iss(0);
        bus.rs_addr = 0;
        bus.rt_addr = 0;
        chk("zero_pre", 0, 0, 0, 0, 0);
        step();
        idle();
        chk("zero_post", 0, 0, 0, 0, 0);
        step();

        iss(7);
        bus.rs_addr = 7;
        bus.rt_addr = 3;
        chk("issue7_pre", 0, 32'h12345678, 0, 0, 0);
        step();
        idle();
        chk("issue7_post", 0, 32'h12345678, 1, 0, 1);
        step();
        wr(7, 32'h55);
        chk("wr7_pre", BYP ? 32'h55 : 32'h0, 32'h12345678,
            !BYP, 0, 1);
        step();
        idle();
        chk("wr7_post", 32'h55, 32'h12345678, 0, 0, 0);
        step();

        iss(9);
        step();
        idle();
        bus.rs_addr = 9;
        bus.rt_addr = 7;
        chk("r9_busy", 0, 32'h55, 1, 0, 1);
        step();
        iss(9);
        wr(9, 32'h77);
        chk("r9_both_pre", BYP ? 32'h77 : 32'h0, 32'h55, 1, 0, 1);
        step();
        idle();
        chk("r9_both_post", 32'h77, 32'h55, 1, 0, 1);
        step();
        wr(9, 32'h88);
        step();
        idle();
        chk("r9_cleared", 32'h88, 32'h55, 0, 0, 0);
        step();

        iss(9);
        step();
        step();
        idle();
        chk("r9_reissued", 32'h88, 32'h55, 1, 0, 1);
        step();
        wr(9, 32'h99);
        step();
        idle();
        chk("r9_single_clear", 32'h99, 32'h55, 0, 0, 0);
        step();

        wr(4, 32'hCAFE);
        bus.rs_addr = 4;
        bus.rt_addr = 3;
        chk("byp_r4_pre", BYP ? 32'hCAFE : 32'h0, 32'h12345678,
            0, 0, 0);
        step();
        idle();
        chk("r4_post", 32'hCAFE, 32'h12345678, 0, 0, 0);
        step();

        bus.rs_addr = 31;
        bus.rt_addr = 31;
        chk("same_reg", 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 0);
        step();

        iss(10);
        wr(11, 32'hBB);
        step();
        idle();
        bus.rs_addr = 10;
        bus.rt_addr = 11;
        chk("mixed", 0, 32'hBB, 1, 0, 1);
        step();

        for (int k = 0; k < 10 && q.size() != 0; k++) begin
            @(posedge clk);
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
